// File: rtl/bsg_print_stat_arbiter.sv
// Merges per-port print-stat snoop events through per-port FIFOs and a round-robin output stage.
// Optional capture timestamps are enabled by defining BSG_PRINT_STAT_TIMESTAMP_EN.
module bsg_print_stat_arbiter #(
  parameter int unsigned num_ports_p  = 2,
  parameter int unsigned data_width_p = 32,
  parameter int unsigned els_p        = 4,
  parameter int unsigned ts_width_p   = 32
) (
  input  logic                                  clk_i,
  input  logic                                  reset_n_i,
  input  logic [num_ports_p-1:0]                v_i,
  input  logic [num_ports_p*data_width_p-1:0]   tag_i,
  output logic                                  v_o,
  input  logic                                  ready_i,
  output logic [data_width_p-1:0]               tag_o,
  output logic [((num_ports_p > 1) ? $clog2(num_ports_p) : 1)-1:0] port_o,
  output logic [ts_width_p-1:0]                 timestamp_o,
  input  logic                                  clear_i,
  output logic [num_ports_p-1:0]                overflow_o,
  output logic [31:0]                           drop_count_o
);

  localparam int unsigned PortW = (num_ports_p > 1) ? $clog2(num_ports_p) : 1;
  localparam int unsigned AddrW = $clog2(els_p);
  localparam int unsigned CntW  = AddrW + 1;

  typedef enum logic {IDLE = 1'b0, HOLD = 1'b1} state_e;

  state_e                  state_q;
  logic [PortW-1:0]        ptr_q, gnt_idx, port_q;
  logic                    gnt_v, load;
  logic [data_width_p-1:0] tag_q, sel_tag;
  logic [data_width_p-1:0] tag_in    [num_ports_p];
  logic [data_width_p-1:0] tag_mem_q [num_ports_p][els_p];
  logic [AddrW-1:0]        wr_ptr_q  [num_ports_p];
  logic [AddrW-1:0]        rd_ptr_q  [num_ports_p];
  logic [CntW-1:0]         cnt_q     [num_ports_p];
  logic [num_ports_p-1:0]  nonempty, pop, deq, enq, drop;
  logic [num_ports_p-1:0]  overflow_q;
  logic [31:0]             drop_cnt_q;
  logic [32:0]             n_drop, drop_sum;

  always_comb begin
    for (int unsigned p = 0; p < num_ports_p; p++) begin
      tag_in[p] = tag_i[p*data_width_p +: data_width_p];
    end
  end

  // An incoming strobe on an empty FIFO counts as its head, giving single-cycle latency.
  always_comb begin
    for (int unsigned p = 0; p < num_ports_p; p++) begin
      nonempty[p] = (cnt_q[p] != '0) || v_i[p];
    end
  end

  always_comb begin : grant_comb
    int unsigned idx;
    gnt_v   = 1'b0;
    gnt_idx = '0;
    idx     = 0;
    for (int unsigned i = 0; i < num_ports_p; i++) begin
      idx = (32'(ptr_q) + i) % num_ports_p;
      if (!gnt_v && nonempty[idx[PortW-1:0]]) begin
        gnt_v   = 1'b1;
        gnt_idx = idx[PortW-1:0];
      end
    end
  end

  assign load = gnt_v && ((state_q == IDLE) || ready_i);

  // Bypassed events (granted while their FIFO is empty) are never written into storage.
  always_comb begin
    for (int unsigned p = 0; p < num_ports_p; p++) begin
      pop[p]  = load && (gnt_idx == PortW'(p));
      deq[p]  = pop[p] && (cnt_q[p] != '0);
      enq[p]  = v_i[p] && !(pop[p] && (cnt_q[p] == '0))
                && ((cnt_q[p] != CntW'(els_p)) || pop[p]);
      drop[p] = v_i[p] && (cnt_q[p] == CntW'(els_p)) && !pop[p];
    end
  end

  always_comb begin
    sel_tag = tag_mem_q[gnt_idx][rd_ptr_q[gnt_idx]];
    if (cnt_q[gnt_idx] == '0) sel_tag = tag_in[gnt_idx];
  end

  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      for (int unsigned p = 0; p < num_ports_p; p++) begin
        wr_ptr_q[p] <= '0;
        rd_ptr_q[p] <= '0;
        cnt_q[p]    <= '0;
      end
    end else begin
      for (int unsigned p = 0; p < num_ports_p; p++) begin
        if (enq[p]) wr_ptr_q[p] <= wr_ptr_q[p] + AddrW'(1);
        if (deq[p]) rd_ptr_q[p] <= rd_ptr_q[p] + AddrW'(1);
        cnt_q[p] <= cnt_q[p] + CntW'(enq[p]) - CntW'(deq[p]);
      end
    end
  end

  always_ff @(posedge clk_i) begin
    for (int unsigned p = 0; p < num_ports_p; p++) begin
      if (enq[p]) tag_mem_q[p][wr_ptr_q[p]] <= tag_in[p];
    end
  end

  // Output stage: IDLE/HOLD with a loaded output register and round-robin pointer.
  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      state_q <= IDLE;
      ptr_q   <= '0;
      tag_q   <= '0;
      port_q  <= '0;
    end else if (load) begin
      state_q <= HOLD;
      tag_q   <= sel_tag;
      port_q  <= gnt_idx;
      ptr_q   <= (32'(gnt_idx) == num_ports_p - 1) ? '0 : gnt_idx + PortW'(1);
    end else if ((state_q == HOLD) && ready_i) begin
      state_q <= IDLE;
    end
  end

  // Drops in a clear cycle land on top of the cleared statistics.
  always_comb begin
    n_drop = '0;
    for (int unsigned p = 0; p < num_ports_p; p++) begin
      n_drop = n_drop + 33'(drop[p]);
    end
    drop_sum = (clear_i ? 33'd0 : {1'b0, drop_cnt_q}) + n_drop;
  end

  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      overflow_q <= '0;
      drop_cnt_q <= '0;
    end else begin
      overflow_q <= (clear_i ? '0 : overflow_q) | drop;
      drop_cnt_q <= drop_sum[32] ? 32'hFFFF_FFFF : drop_sum[31:0];
    end
  end

`ifdef BSG_PRINT_STAT_TIMESTAMP_EN
  logic [ts_width_p-1:0] ts_cnt_q, ts_out_q, sel_ts;
  logic [ts_width_p-1:0] ts_mem_q [num_ports_p][els_p];

  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      ts_cnt_q <= '0;
      ts_out_q <= '0;
    end else begin
      ts_cnt_q <= ts_cnt_q + ts_width_p'(1);
      if (load) ts_out_q <= sel_ts;
    end
  end

  always_ff @(posedge clk_i) begin
    for (int unsigned p = 0; p < num_ports_p; p++) begin
      if (enq[p]) ts_mem_q[p][wr_ptr_q[p]] <= ts_cnt_q;
    end
  end

  always_comb begin
    sel_ts = ts_mem_q[gnt_idx][rd_ptr_q[gnt_idx]];
    if (cnt_q[gnt_idx] == '0) sel_ts = ts_cnt_q;
  end

  assign timestamp_o = ts_out_q;
`else
  assign timestamp_o = '0;
`endif

  assign v_o          = (state_q == HOLD);
  assign tag_o        = tag_q;
  assign port_o       = port_q;
  assign overflow_o   = overflow_q;
  assign drop_count_o = drop_cnt_q;

endmodule

// File: doc/bsg_print_stat_arbiter.md
BSG_PRINT_STAT_ARBITER -- requirements
Module: bsg_print_stat_arbiter

Interface
REQ-001 Parameter num_ports_p, default 2: number of print-stat snoop sources merged.
REQ-002 Parameter data_width_p, default 32: print-stat tag width.
REQ-003 Parameter els_p, default 4: per-port FIFO depth; power of two, at least 2.
REQ-004 Parameter ts_width_p, default 32: timestamp counter width.
REQ-005 clk_i  input  1  sole clock; all state updates on its rising edge.
REQ-006 reset_n_i  input  1  asynchronous, active-low reset.
REQ-007 v_i  input  num_ports_p  per-port print-stat strobe, one event per cycle per port, no backpressure.
REQ-008 tag_i  input  num_ports_p*data_width_p  per-port tag; port p occupies bits [p*data_width_p +: data_width_p].
REQ-009 v_o  output  1  merged event valid.
REQ-010 ready_i  input  1  host consumer ready.
REQ-011 tag_o  output  data_width_p  tag of the presented event.
REQ-012 port_o  output  max(1,clog2(num_ports_p))  source port of the presented event.
REQ-013 timestamp_o  output  ts_width_p  capture cycle of the presented event.
REQ-014 clear_i  input  1  synchronous clear of overflow_o and drop_count_o.
REQ-015 overflow_o  output  num_ports_p  sticky per-port drop flag.
REQ-016 drop_count_o  output  32  saturating total of dropped events.

Function
REQ-017 Each port SHALL own an els_p-entry FIFO holding {tag, timestamp}; v_i[p] enqueues tag_i slice p.
REQ-018 Enqueue into a full FIFO SHALL be dropped unless that FIFO is popped in the same cycle, in which case the event is accepted.
REQ-019 A drop SHALL set overflow_o[p] and add the number of ports dropping this cycle to drop_count_o, saturating at 32'hFFFF_FFFF.
REQ-020 clear_i SHALL zero overflow_o and drop_count_o; drops in the clear cycle take priority and are recorded after the clear.
REQ-021 Output stage FSM SHALL have states IDLE (v_o=0) and HOLD (v_o=1, output register loaded).
REQ-022 IDLE: if any FIFO is non-empty, grant one port, pop it, load the output register, go to HOLD; else stay.
REQ-023 HOLD without ready_i: tag_o, port_o, timestamp_o SHALL stay stable and no pop occurs.
REQ-024 HOLD with ready_i: if any FIFO is non-empty, grant, pop and reload in the same cycle and stay in HOLD; else go to IDLE.
REQ-025 Grant SHALL be round-robin: first non-empty port at or above the pointer, wrapping from num_ports_p-1 to 0.
REQ-026 The pointer SHALL move to granted port +1 (mod num_ports_p) only on a grant.
REQ-027 Minimum latency: v_i at cycle N into an empty block SHALL give v_o=1 at cycle N+1.
REQ-028 Sustained throughput SHALL be one event per cycle while ready_i stays high.
REQ-029 Per-port order SHALL be preserved; no event is duplicated or lost except by REQ-018 drops.

Reset
REQ-030 Asserting reset_n_i low SHALL, without a clock edge, empty all FIFOs, enter IDLE, drive v_o=0, set the pointer, overflow_o, drop_count_o and timestamp counter to 0.
REQ-031 tag_o, port_o and timestamp_o SHALL read 0 during and after reset until the first load.
REQ-032 Reset mid-operation SHALL discard all queued and held events; the first event after deassertion follows REQ-027.

Configuration
REQ-033 Macro BSG_PRINT_STAT_TIMESTAMP_EN defined: a free-running ts_width_p counter increments every cycle, wraps to 0 and is captured at enqueue.
REQ-034 Macro BSG_PRINT_STAT_TIMESTAMP_EN undefined: no counter and no timestamp storage; timestamp_o SHALL be constant 0.

Verification
REQ-035 Single event: v_i=2'b01, tag 0x1234 at cycle 5 -> v_o=1 at cycle 6, tag_o=0x1234, port_o=0, timestamp_o=5 with the macro on.
REQ-036 Contention: both ports strobe every cycle for 8 cycles with ready_i=1 -> ports alternate 0,1,0,1..., each port in order, no drops with els_p=4.
REQ-037 Backpressure: ready_i=0 for 10 cycles while port 1 strobes 6 events -> output stable; 5 events kept (1 held + 4 queued); overflow_o=2'b10; drop_count_o=1.
REQ-038 Full plus pop: port 0 FIFO full, ready_i=1 and v_i[0]=1 in the same cycle -> event accepted, no drop.
REQ-039 Clear and reset: clear_i=1 -> overflow_o=0, drop_count_o=0 next cycle; reset_n_i low while in HOLD -> v_o=0 immediately, all FIFOs empty.
REQ-040 Macro off: repeat REQ-035 -> timestamp_o=0 throughout, all other outputs identical.
